// File: rtl/aes_block_loader.sv
// aes_block_loader
//   Collects a 16-byte plaintext block from a byte stream, hands it to an
//   external encrypt core together with the key, waits a fixed number of
//   cycles for the core, then captures and presents the ciphertext.
//
// Parameters
//   ENC_CYCLES  cycles from the enc_start pulse to CipherText being valid (2..255)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   in_data     plaintext byte stream
//   in_valid    in_data is valid
//   in_ready    loader accepts a byte this cycle (LOAD only)
//   key_in      encryption key, captured with byte 0 of each block
//   PlainText   assembled block (byte 0 in the top byte)
//   SecretKey   key driven to the encrypt core
//   enc_start   one-cycle pulse on the first cycle after the block completes
//   CipherText  result from the encrypt core
//   out_block   captured ciphertext
//   out_valid   out_block is valid
//   out_ready   downstream accepts out_block
//   busy        high while waiting on the core or presenting the result
module aes_block_loader #(
  parameter int unsigned ENC_CYCLES = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
  output logic [127:0] PlainText,
  output logic [127:0] SecretKey,
  output logic         enc_start,
  input  logic [127:0] CipherText,
  output logic [127:0] out_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [7:0] TIMER_LOAD = 8'(ENC_CYCLES);

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    WAIT = 2'b01,
    OUT  = 2'b10
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [3:0]  byteCnt;
  logic [7:0]  timer;
  logic        readyEn;
  logic        accept;
  logic        lastByte;
  logic [6:0]  wrMsb;

  // Byte k lands at PlainText[127-8k -: 8].
  assign wrMsb = 7'd127 - {byteCnt, 3'b000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    lastByte  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = readyEn;
        accept   = in_valid & readyEn;
        lastByte = accept && (byteCnt == 4'd15);
        if (lastByte) begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (timer == 8'd1) begin
          stateNext = OUT;
        end
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          stateNext = LOAD;
        end
      end
      default: begin
        stateNext = LOAD;
      end
    endcase
  end

  // readyEn holds in_ready low while reset is asserted and lets it rise one
  // cycle after release, even though the state register already reads LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readyEn   <= 1'b0;
      byteCnt   <= '0;
      timer     <= '0;
      PlainText <= '0;
      SecretKey <= '0;
      enc_start <= 1'b0;
      out_block <= '0;
    end else begin
      readyEn   <= 1'b1;
      enc_start <= lastByte;
      if (accept) begin
        PlainText[wrMsb -: 8] <= in_data;
        byteCnt               <= byteCnt + 4'd1;
        if (byteCnt == 4'd0) begin
          SecretKey <= key_in;
        end
      end
      if (lastByte) begin
        timer <= TIMER_LOAD;
      end else if (state == WAIT) begin
        timer <= timer - 8'd1;
      end
      if ((state == WAIT) && (timer == 8'd1)) begin
        out_block <= CipherText;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: two instances (ENC_CYCLES 14 and 2) on one clock,
// each with its own randomized driver, reference queue and monitor.
module tb_aes_block_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned nCmp = 0;
  int unsigned nErr = 0;
  logic [31:0] salt = 32'h0;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    int unsigned  encCyc;
    int unsigned  riseCyc;
  } exp_t;

  // Encrypt-core stand-in: a value that differs every cycle, so the capture
  // edge is pinned down exactly.
  function automatic logic [127:0] ctOf(input int unsigned k, input logic [31:0] s);
    return {k * 32'h9E3779B9, ~k, k ^ 32'hA5A55A5A, k + s};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int unsigned N = (g == 0) ? 14 : 2;

    logic         reset = 1'b1;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] key_in = '0;
    logic [127:0] PlainText;
    logic [127:0] SecretKey;
    logic         enc_start;
    logic [127:0] CipherText;
    logic [127:0] out_block;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;

    assign CipherText = ctOf(cyc, salt);

    aes_block_loader #(.ENC_CYCLES(N)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .key_in(key_in), .PlainText(PlainText),
      .SecretKey(SecretKey), .enc_start(enc_start), .CipherText(CipherText),
      .out_block(out_block), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy)
    );

    exp_t         encQ[$];
    logic [127:0] ptModel = '0;
    logic [127:0] keyModel = '0;
    int unsigned  expReadyCyc = 0;
    int unsigned  lastB0 = 0;
    int unsigned  bpHold = 0;
    bit           forceReady = 1'b0;
    bit           active = 1'b0;
    bit           doneFlag = 1'b0;

    function automatic string nm(input string s);
      return $sformatf("n%0d.%s", N, s);
    endfunction

    task automatic doReset(input int unsigned hold);
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      active = 1'b0;
      bpHold = 0;
      encQ.delete();
      ptModel = '0;
      keyModel = '0;
      #1;
      chk(nm("rstInReady"), in_ready, 0);
      chk(nm("rstPlainText"), PlainText, 0);
      chk(nm("rstSecretKey"), SecretKey, 0);
      chk(nm("rstOutBlock"), out_block, 0);
      chk(nm("rstOutValid"), out_valid, 0);
      chk(nm("rstEncStart"), enc_start, 0);
      chk(nm("rstBusy"), busy, 0);
      repeat (hold) @(negedge clk);
      reset = 1'b0;
      expReadyCyc = cyc + 1;
    endtask

    // Waits for the loader, then drives nBytes bytes; junk (0xAA with random
    // in_valid) is driven while the loader is not ready.
    task automatic sendBlock(input logic [7:0] base, input bit rnd, input int unsigned gapMode,
                             input logic [127:0] key, input int unsigned nBytes);
      int unsigned w;
      int unsigned gap;
      logic [7:0]  b;
      exp_t        e;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 300) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 8'hAA;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        w++;
        @(negedge clk);
      end
      if (!in_ready) begin
        chk(nm("readyTimeout"), 0, 1);
        return;
      end
      chk(nm("readyRise"), cyc, expReadyCyc);
      for (int k = 0; k < int'(nBytes); k++) begin
        if (k > 0 && gapMode != 0) begin
          gap = (gapMode == 1) ? 1 : $urandom_range(0, 2);
          repeat (gap) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            @(negedge clk);
          end
        end
        b = rnd ? 8'($urandom) : base + 8'(k);
        in_valid = 1'b1;
        in_data = b;
        key_in = (k == 0) ? key : {$urandom, $urandom, $urandom, $urandom};
        chk(nm("readyLoad"), in_ready, 1);
        ptModel[127 - 8 * k -: 8] = b;
        if (k == 0) begin
          keyModel = key;
          lastB0 = cyc;
        end
        if (k == 15) begin
          e.pt = ptModel;
          e.key = keyModel;
          e.ct = ctOf(cyc + N, salt);
          e.encCyc = cyc + 1;
          e.riseCyc = cyc + N + 1;
          encQ.push_back(e);
        end
        @(negedge clk);
        chk(nm("plainText"), PlainText, ptModel);
        chk(nm("secretKey"), SecretKey, keyModel);
      end
      in_valid = (nBytes == 16);
      in_data = 8'hAA;
      key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Monitor: pops the expected block when enc_start is due and checks the
    // whole WAIT/OUT window against it.
    initial begin
      exp_t cur;
      bit   expEnc;
      bit   expValid;
      forever begin
        @(negedge clk);
        if (reset) begin
          out_ready = 1'b0;
          continue;
        end
        expEnc = (encQ.size() > 0) && (encQ[0].encCyc == cyc);
        chk(nm("encStart"), enc_start, expEnc);
        if (expEnc) begin
          cur = encQ.pop_front();
          active = 1'b1;
        end
        if (active) begin
          expValid = (cyc >= cur.riseCyc);
          chk(nm("outValid"), out_valid, expValid);
          chk(nm("busyActive"), busy, 1);
          chk(nm("readyBusy"), in_ready, 0);
          chk(nm("ptHold"), PlainText, cur.pt);
          chk(nm("keyHold"), SecretKey, cur.key);
          if (expValid) begin
            chk(nm("outBlock"), out_block, cur.ct);
            if (bpHold > 0) begin
              out_ready = 1'b0;
              bpHold--;
            end else begin
              out_ready = forceReady | 1'($urandom_range(0, 1));
            end
            if (out_ready) begin
              active = 1'b0;
              expReadyCyc = cyc + 1;
            end
          end else begin
            out_ready = 1'($urandom_range(0, 1));
          end
        end else begin
          chk(nm("outValidIdle"), out_valid, 0);
          chk(nm("busyIdle"), busy, 0);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    end

    initial begin
      int unsigned b0a;
      doReset(3);
      sendBlock(8'h00, 1'b0, 0, 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C, 16);
      chk(nm("basicPT"), PlainText, 128'h00010203_04050607_08090A0B_0C0D0E0F);
      chk(nm("basicKey"), SecretKey, 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C);
      sendBlock(8'h30, 1'b0, 1, {$urandom, $urandom, $urandom, $urandom}, 16);
      bpHold = 20;
      sendBlock(8'h00, 1'b1, 2, {$urandom, $urandom, $urandom, $urandom}, 16);
      sendBlock(8'h00, 1'b1, 0, {$urandom, $urandom, $urandom, $urandom}, 10);
      doReset(2);
      sendBlock(8'hF0, 1'b0, 0, {$urandom, $urandom, $urandom, $urandom}, 16);
      chk(nm("rstBlockPT"), PlainText, 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF);
      sendBlock(8'h00, 1'b1, 2, {$urandom, $urandom, $urandom, $urandom}, 16);
      doReset(2);
      bpHold = 1000;
      sendBlock(8'h00, 1'b1, 0, {$urandom, $urandom, $urandom, $urandom}, 16);
      repeat (N + 3) @(negedge clk);
      doReset(2);
      for (int i = 0; i < 6; i++) begin
        sendBlock(8'h00, 1'b1, $urandom_range(0, 2), {$urandom, $urandom, $urandom, $urandom}, 16);
      end
      forceReady = 1'b1;
      sendBlock(8'h00, 1'b1, 0, {$urandom, $urandom, $urandom, $urandom}, 16);
      b0a = lastB0;
      sendBlock(8'h00, 1'b1, 0, {$urandom, $urandom, $urandom, $urandom}, 16);
      chk(nm("period"), lastB0 - b0a, 17 + N);
      in_valid = 1'b0;
      for (int i = 0; i < 200 && (active || encQ.size() > 0); i++) @(negedge clk);
      chk(nm("drain"), active, 0);
      doneFlag = 1'b1;
    end
  end

  initial begin
    salt = $urandom;
    for (int i = 0; i < 60000 && !(inst[0].doneFlag && inst[1].doneFlag); i++) @(posedge clk);
    if (!(inst[0].doneFlag && inst[1].doneFlag)) begin
      nCmp++;
      nErr++;
      $display("FAIL timeout: done=%b%b required 11", inst[1].doneFlag, inst[0].doneFlag);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/aes_block_loader.md
AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 Parameter ENC_CYCLES, default 14, SHALL set the number of clk cycles from the enc_start pulse to CipherText being valid; legal range 2..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  8  plaintext byte stream.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  loader accepts a byte this cycle.
REQ-007 key_in  input  128  encryption key.
REQ-008 PlainText  output  128  assembled block driven to the encrypt core.
REQ-009 SecretKey  output  128  key driven to the encrypt core.
REQ-010 enc_start  output  1  one-cycle pulse that starts the encrypt core.
REQ-011 CipherText  input  128  result from the encrypt core.
REQ-012 out_block  output  128  captured ciphertext.
REQ-013 out_valid  output  1  out_block is valid.
REQ-014 out_ready  input  1  downstream accepts out_block.
REQ-015 busy  output  1  high in WAIT and OUT.

Function
REQ-016 States SHALL be LOAD, WAIT and OUT, encoded in 2 bits; the unused encoding SHALL return to LOAD on the next edge.
REQ-017 LOAD: in_ready=1; a byte is accepted on an edge where in_valid&in_ready; a 4-bit byte counter counts accepted bytes 0..15.
REQ-018 Byte k (k=0 first) SHALL be written to PlainText[127-8k -: 8]; PlainText bits not yet written in the current block SHALL hold their previous values.
REQ-019 key_in SHALL be captured into SecretKey on the edge that accepts byte 0, and held until byte 0 of the next block.
REQ-020 On the acceptance of byte 15: the counter wraps to 0, state goes to WAIT, and an 8-bit timer loads ENC_CYCLES.
REQ-021 enc_start SHALL be 1 on exactly the first WAIT cycle and 0 at all other times.
REQ-022 WAIT: in_ready=0; the timer decrements by 1 per cycle; PlainText and SecretKey stay constant.
REQ-023 On the WAIT edge where the timer equals 1: out_block <= CipherText, and state goes to OUT; out_valid therefore rises exactly ENC_CYCLES cycles after the enc_start cycle.
REQ-024 OUT: out_valid=1 and out_block is held stable while out_ready=0; on an edge with out_ready=1, state goes to LOAD and out_valid falls.
REQ-025 in_valid in WAIT or OUT SHALL be ignored, and no byte SHALL be consumed.
REQ-026 out_ready while not in OUT SHALL be ignored.
REQ-027 A single in_valid/in_ready handshake SHALL consume exactly one byte; back-to-back bytes on consecutive cycles SHALL all be accepted.
REQ-028 Minimum block period SHALL be 16 + ENC_CYCLES + 1 cycles with in_valid=1 and out_ready=1 held continuously.

Reset
REQ-029 While reset=1: state=LOAD, counter=0, timer=0, PlainText=0, SecretKey=0, out_block=0, out_valid=0, enc_start=0, busy=0, in_ready=0.
REQ-030 in_ready SHALL rise on the first clk cycle after reset deasserts.
REQ-031 Reset asserted mid-LOAD, mid-WAIT or in OUT SHALL discard any partial block and pending output; no out_valid SHALL appear without a new complete 16-byte block.

Verification
REQ-032 Basic: ENC_CYCLES=14; key_in=0x2B7E1516_28AED2A6_ABF71588_09CF4F3C; bytes 0x00..0x0F on consecutive cycles -> PlainText=0x00010203_04050607_08090A0B_0C0D0E0F and SecretKey equal to key_in; enc_start high for 1 cycle; out_valid rises 14 cycles later with out_block equal to CipherText sampled on that edge.
REQ-033 Gapped input: in_valid toggled 1,0,1,0 over 32 cycles -> exactly 16 bytes accepted; PlainText correct; a single enc_start pulse.
REQ-034 Output backpressure: out_ready=0 for 20 cycles in OUT, then 1 -> out_valid and out_block stable for all 20 cycles; return to LOAD one edge after out_ready=1; in_ready=0 throughout.
REQ-035 Reset mid-operation: reset pulsed after byte 9, then a full block 0xF0..0xFF -> PlainText=0xF0F1...FF; exactly one enc_start pulse and one output.
REQ-036 Ignored inputs: in_valid=1 during WAIT and OUT with in_data=0xAA -> the next block's byte 0 comes only from LOAD; counter reads 0 at LOAD entry.
REQ-037 Boundary: ENC_CYCLES=2 -> out_valid rises 2 cycles after enc_start; back-to-back blocks with out_ready=1 give a period of 19 cycles.
